// File: rtl/des_perm_pipe.sv
// des_perm_pipe: pipelined DES initial / final permutation over LANES 64-bit blocks.
// Each transaction selects IP, FP (IP^-1) or bypass. The permutation is applied
// combinationally, and the result then moves through a STAGES-deep register
// pipeline with a valid/ready handshake. A sideband tag travels with the data.
module des_perm_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [64*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy,
  output logic [31:0]           blk_count
);

  localparam int DW   = 64 * LANES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] stageValid_q, stageValid_d;
  logic [DW-1:0]     stageData_q [STAGES];
  logic [DW-1:0]     stageData_d [STAGES];
  logic [TAG_W-1:0]  stageTag_q  [STAGES];
  logic [TAG_W-1:0]  stageTag_d  [STAGES];
  logic [31:0]       blkCount_q, blkCount_d;
  logic [STAGES-1:0] stageLoad;
  logic [DW-1:0]     permData;

  // DES bit n is data bit 64-n, so DES bit 1 is the MSB.
  // Both tables are generated arithmetically from their row/column structure:
  //   IP rows 0-3 start at 58,60,62,64 and rows 4-7 start at 57,59,61,63, stepping down by 8.
  //   FP even columns hold 40-row, 48-row, ..., and odd columns hold 8-row, 16-row, ...
  function automatic logic [63:0] desPermute(input logic [63:0] blk, input logic inverse);
    logic [63:0] res;
    int row;
    int col;
    int src;
    res = '0;
    for (int i = 1; i <= 64; i++) begin
      row = (i - 1) / 8;
      col = (i - 1) % 8;
      if (!inverse)
        src = (row < 4) ? (58 + 2 * row - 8 * col) : (57 + 2 * (row - 4) - 8 * col);
      else
        src = (col % 2 == 0) ? (40 - row + 8 * (col / 2)) : (8 - row + 8 * (col / 2));
      res[64 - i] = blk[64 - src];
    end
    return res;
  endfunction

  // Apply the selected permutation to every lane in front of stage 0.
  always_comb begin
    permData = in_data;
    for (int l = 0; l < LANES; l++) begin
      case (in_mode)
        2'b00:   permData[64*l +: 64] = desPermute(in_data[64*l +: 64], 1'b0);
        2'b01:   permData[64*l +: 64] = desPermute(in_data[64*l +: 64], 1'b1);
        default: permData[64*l +: 64] = in_data[64*l +: 64];
      endcase
    end
  end

  // A stage may load if it is empty or its successor may load, so a ready
  // downstream lets the whole pipe advance in one cycle with no bubbles.
  always_comb begin
    logic chain;
    stageLoad = '0;
    chain = !stageValid_q[LAST] || out_ready;
    stageLoad[LAST] = chain;
    for (int k = LAST - 1; k >= 0; k--) begin
      chain = !stageValid_q[k] || chain;
      stageLoad[k] = chain;
    end
  end

  assign in_ready = stageLoad[0] && !clr;

  // Next-state logic: shift the stages that may load, take the new entry into
  // stage 0, and flush the valid bits on clr. Data is left stale on a flush.
  always_comb begin
    stageValid_d = stageValid_q;
    stageData_d  = stageData_q;
    stageTag_d   = stageTag_q;
    blkCount_d   = blkCount_q;
    if (in_valid && in_ready)
      blkCount_d = blkCount_q + 32'd1;
    if (clr) begin
      stageValid_d = '0;
    end else begin
      for (int k = LAST; k >= 1; k--) begin
        if (stageLoad[k]) begin
          stageValid_d[k] = stageValid_q[k-1];
          stageData_d[k]  = stageData_q[k-1];
          stageTag_d[k]   = stageTag_q[k-1];
        end
      end
      if (stageLoad[0]) begin
        stageValid_d[0] = in_valid;
        stageData_d[0]  = permData;
        stageTag_d[0]   = in_tag;
      end
    end
  end

  // Pipeline and counter registers. Reset clears everything, including any data in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageValid_q <= '0;
      stageData_q  <= '{default: '0};
      stageTag_q   <= '{default: '0};
      blkCount_q   <= '0;
    end else begin
      stageValid_q <= stageValid_d;
      stageData_q  <= stageData_d;
      stageTag_q   <= stageTag_d;
      blkCount_q   <= blkCount_d;
    end
  end

  assign out_valid = stageValid_q[LAST];
  assign out_data  = stageData_q[LAST];
  assign out_tag   = stageTag_q[LAST];
  assign busy      = |stageValid_q;
  assign blk_count = blkCount_q;

endmodule
